// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: table FSM states, counter init value and
// the PC/history index hash used by both the BHT and the BTB.
package bp_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  // Weakly not-taken: the value just below the counter midpoint.
  function automatic int unsigned bp_init_val(input int unsigned cnt_w);
    return (32'd1 << (cnt_w - 1)) - 32'd1;
  endfunction

  // Word-aligned PC bits, optionally folded with zero-extended global history.
  function automatic logic [31:0] bp_index(input logic [31:0] pc,
                                           input logic [31:0] ghr,
                                           input int unsigned addr_len,
                                           input bit          gshare);
    logic [31:0] idx;
    idx = (pc >> 2) & ((32'd1 << addr_len) - 32'd1);
    if (gshare)
      idx = idx ^ ghr;
    return idx;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for an up/down saturating counter.
module bp_sat_counter #(
  parameter int CNT_WIDTH = 2
) (
  input  logic [CNT_WIDTH-1:0] value,
  input  logic                 taken,
  output logic [CNT_WIDTH-1:0] next_value
);

  always_comb begin
    next_value = value;
    if (taken && (value != {CNT_WIDTH{1'b1}}))
      next_value = value + CNT_WIDTH'(1);
    else if (!taken && (value != '0))
      next_value = value - CNT_WIDTH'(1);
  end

endmodule

// File: rtl/gshare_bht.sv
// Branch history table with optional gshare indexing, speculative global
// history and a power-up sweep that seeds every counter weakly not-taken.
module gshare_bht
  import bp_pkg::*;
#(
  parameter int TABLE_ADDR_LEN = 12,
  parameter int CNT_WIDTH      = 2,
  parameter int GHR_LEN        = 8,
  parameter int MODE           = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        rd_PC,
  input  logic               rd_valid,
  output logic               rd_predicted_taken,
  output logic [GHR_LEN-1:0] rd_ghr,
  input  logic               wr_req,
  input  logic [31:0]        wr_PC,
  input  logic               wr_taken,
  input  logic [GHR_LEN-1:0] wr_ghr,
  input  logic               wr_mispredict,
  output logic               init_done
);

  localparam int TABLE_SIZE = 1 << TABLE_ADDR_LEN;
  localparam logic [CNT_WIDTH-1:0]      INIT_VAL = CNT_WIDTH'(bp_init_val(CNT_WIDTH));
  localparam logic [TABLE_ADDR_LEN-1:0] IDX_LAST = '1;

  bp_state_e                 state;
  logic [TABLE_ADDR_LEN-1:0] init_idx;
  logic [GHR_LEN-1:0]        ghr;
  logic [CNT_WIDTH-1:0]      table_mem [TABLE_SIZE];

  logic [31:0]               rd_hash, wr_hash;
  logic [TABLE_ADDR_LEN-1:0] rd_idx, wr_idx;
  logic [CNT_WIDTH-1:0]      rd_cnt, wr_cnt, upd_cnt;
  logic [GHR_LEN-1:0]        ghr_spec, ghr_restore;

  logic                      mem_we;
  logic [TABLE_ADDR_LEN-1:0] mem_addr;
  logic [CNT_WIDTH-1:0]      mem_data;

  // Update indexing uses the checkpointed history, never the live register.
  assign rd_hash = bp_index(rd_PC, 32'(ghr),    TABLE_ADDR_LEN, MODE == 1);
  assign wr_hash = bp_index(wr_PC, 32'(wr_ghr), TABLE_ADDR_LEN, MODE == 1);
  assign rd_idx  = rd_hash[TABLE_ADDR_LEN-1:0];
  assign wr_idx  = wr_hash[TABLE_ADDR_LEN-1:0];

  assign rd_cnt = table_mem[rd_idx];
  assign wr_cnt = table_mem[wr_idx];

  assign init_done          = (state == ST_RUN);
  assign rd_predicted_taken = init_done & rd_cnt[CNT_WIDTH-1];
  assign rd_ghr             = ghr;

  bp_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_sat (
    .value      (wr_cnt),
    .taken      (wr_taken),
    .next_value (upd_cnt)
  );

  generate
    if (GHR_LEN == 1) begin : g_ghr1
      assign ghr_spec    = rd_predicted_taken;
      assign ghr_restore = wr_taken;
    end else begin : g_ghrn
      assign ghr_spec    = {ghr[GHR_LEN-2:0], rd_predicted_taken};
      assign ghr_restore = {wr_ghr[GHR_LEN-2:0], wr_taken};
    end
  endgenerate

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = wr_idx;
    mem_data = upd_cnt;
    if (state == ST_INIT) begin
      mem_we   = 1'b1;
      mem_addr = init_idx;
      mem_data = INIT_VAL;
    end else begin
      mem_we   = wr_req;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      table_mem[mem_addr] <= mem_data;
  end

  // A restoring mispredict squashes any same-cycle wrong-path history shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_idx <= '0;
      ghr      <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == IDX_LAST)
            state <= ST_RUN;
        end
        ST_RUN: begin
          if (wr_req && wr_mispredict)
            ghr <= ghr_restore;
          else if (rd_valid)
            ghr <= ghr_spec;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{rd_hash[31:TABLE_ADDR_LEN], wr_hash[31:TABLE_ADDR_LEN],
                         rd_cnt[CNT_WIDTH-2:0]};

endmodule
